vga_sync_receiver: RTL and testbench
====================================

Name: vga_sync_receiver

Overview:
Sink-side counterpart of the VGA timing generator. It samples HSync/VSync/Display from a same-clock source, recovers pixel column and row coordinates, and measures the line period. It declares lock after a run of consistent lines and flags timing faults. It sits in front of frame-capture and pattern-checking logic and in the loopback bench of the timing generator.

Parameters:
XWidth, 8, width of oCol
YWidth, 8, width of oRow
X_length, 256, max expected active pixels per line; oCol saturates at X_length-1
Y_length, 256, max expected active lines per frame; oRow saturates at Y_length-1
LockLines, 4, consecutive equal line periods required to assert oLocked
MaxPeriod, 16'd2047, sync-edge timeout in cycles

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-low reset
iHSync  input  1  horizontal sync, active low
iVSync  input  1  vertical sync, active low; a VSync pulse replaces the HSync pulse on the frame's final line
iDisplay  input  1  active-video qualifier, active high
oCol  output  XWidth  column of current active pixel
oRow  output  YWidth  row of current active line
oPixelValid  output  1  oCol/oRow refer to an active pixel this cycle
oFrameStart  output  1  one-cycle pulse on VSync falling edge
oLocked  output  1  line timing stable
oLinePeriod  output  16  last measured sync-edge-to-sync-edge period, in cycles
oError  output  1  one-cycle pulse on a timing fault

Behaviour:
- Reset (Reset=0, asynchronous) forces every output to 0 and the FSM to HUNT. Reset also clears the input sample registers (HSync/VSync samples to 1, Display sample to 0), the counters and the match count. Reset mid-frame abandons all state.
- Inputs are registered once (rHS, rVS, rDisp). Edges are detected between successive registered samples. All outputs are registered, so latency from input pin to output is 2 cycles.
- Sync edge (SE): falling edge of rHS or rVS. If both fall in the same cycle, that counts as one SE.
- Period counter: 16-bit, increments every cycle and saturates at 16'hFFFF. It is cleared to 1 on each SE, so an SE occurring P cycles after the previous one yields a measured period of P.
- FSM:
  - HUNT: wait for an SE, then go to MEASURE.
  - MEASURE: on the next SE, store the period in oLinePeriod, set match count to 0, go to TRACK.
  - TRACK: on each SE, compare the period with oLinePeriod.
    - Equal: match count increments and saturates at LockLines. oLocked=1 once the count reaches LockLines.
    - Unequal: oLinePeriod takes the new value, match count=0, oLocked=0. oError pulses only if oLocked was 1. The FSM stays in TRACK.
  - Any state: if the period counter reaches MaxPeriod without an SE, go to HUNT, oLocked=0, and pulse oError if locked.
- Column:
  - On an rDisp rising edge, oCol=0 and oPixelValid=1.
  - While rDisp stays high, oCol increments.
  - At X_length-1, oCol holds; oError pulses once per line on the first overflow cycle.
  - While rDisp is low, oPixelValid=0 and oCol holds its last value.
- Row:
  - Increments on each rDisp falling edge.
  - Saturates at Y_length-1; oError pulses once on overflow.
  - A falling edge of rVS sets oRow=0 and pulses oFrameStart.
  - If the rVS fall and the rDisp fall coincide, the reset to 0 wins.
- Coordinates and oFrameStart operate independently of lock state. Consumers gate on oLocked.

Decomposition:
- Shared package vga_pkg holds the state encodings (STATE_HUNT, STATE_MEASURE, STATE_TRACK).
- vga_pkg also holds the default timing constants shared with the generator: pulse 96, back porch 48, front porch 16.
- One sub-module, vga_edge_detect: a one-bit registered sample plus rise/fall pulses, with reset value as a parameter. It is instantiated three times.

Test Plan:
- Source with 96-cycle HSync, 48 back porch, 256 display, 16 front porch, period 416 cycles -> oLinePeriod=416. oLocked rises on the SE that completes the 4th consecutive equal period after MEASURE. No oError.
- Active line -> oPixelValid high for 256 cycles, 2 cycles after the Display pin rises. oCol steps 0..255. oRow increments by 1 per line.
- VSync pulse instead of HSync on the last line -> oFrameStart pulses once, 2 cycles after the VSync fall. oRow=0. Period is still 416 and lock is retained.
- While locked, one line stretched to 420 cycles -> oError one pulse, oLocked=0, oLinePeriod=420. Lock re-acquired after 4 further matching 416-cycle periods.
- Display held high for 300 cycles -> oCol stops at 255, single oError pulse on that line. Sync lines held high for 2047 cycles -> HUNT, oLocked=0.
- Reset asserted mid-line (async) -> all outputs 0 immediately, without waiting for a clock edge. After release, HUNT, then MEASURE, then relock with no spurious oFrameStart.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: receiver FSM state encoding and the default
// line timing used by the matching timing generator.
package vga_pkg;

    typedef enum logic [1:0] {
        STATE_HUNT,
        STATE_MEASURE,
        STATE_TRACK
    } syncStateT;

    localparam int HSyncPulse = 96;
    localparam int BackPorch  = 48;
    localparam int FrontPorch = 16;

endpackage

// File: rtl/vga_edge_detect.sv
// One-bit input register with rise/fall pulses derived from two successive
// registered samples; the reset value sets the idle level of the line.
module vga_edge_detect #(
    parameter logic ResetValue = 1'b0
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iSignal,
    output logic oSample,
    output logic oRise,
    output logic oFall
);

    logic rPrev;

    // NOTE: non-blocking assignments so rPrev captures the old oSample, not the new one.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oSample <= ResetValue;
            rPrev   <= ResetValue;
        end else begin
            oSample <= iSignal;
            rPrev   <= oSample;
        end
    end

    assign oRise = oSample & ~rPrev;
    assign oFall = ~oSample & rPrev;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel column/row, measures the sync-edge period
// and tracks line-timing lock from HSync/VSync/Display on the same clock.
module vga_sync_receiver
    import vga_pkg::*;
#(
    parameter int          XWidth    = 8,
    parameter int          YWidth    = 8,
    parameter int          X_length  = 256,
    parameter int          Y_length  = 256,
    parameter int          LockLines = 4,
    parameter logic [15:0] MaxPeriod = 16'd2047
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iHSync,
    input  logic              iVSync,
    input  logic              iDisplay,
    output logic [XWidth-1:0] oCol,
    output logic [YWidth-1:0] oRow,
    output logic              oPixelValid,
    output logic              oFrameStart,
    output logic              oLocked,
    output logic [15:0]       oLinePeriod,
    output logic              oError
);

    localparam int                    MatchWidth = $clog2(LockLines + 1);
    localparam logic [MatchWidth-1:0] MatchFull  = MatchWidth'(LockLines);
    localparam logic [MatchWidth-1:0] MatchLast  = MatchWidth'(LockLines - 1);
    localparam logic [MatchWidth-1:0] MatchStep  = MatchWidth'(1);
    localparam logic [XWidth-1:0]     ColMax     = XWidth'(X_length - 1);
    localparam logic [XWidth-1:0]     ColStep    = XWidth'(1);
    localparam logic [YWidth-1:0]     RowMax     = YWidth'(Y_length - 1);
    localparam logic [YWidth-1:0]     RowStep    = YWidth'(1);

    logic hsSample, hsRise, hsFall;
    logic vsSample, vsRise, vsFall;
    logic dispSample, dispRise, dispFall;
    logic unusedSignals;

    vga_edge_detect #(.ResetValue(1'b1)) uHsEdge (
        .Clock(Clock), .Reset(Reset), .iSignal(iHSync),
        .oSample(hsSample), .oRise(hsRise), .oFall(hsFall)
    );

    vga_edge_detect #(.ResetValue(1'b1)) uVsEdge (
        .Clock(Clock), .Reset(Reset), .iSignal(iVSync),
        .oSample(vsSample), .oRise(vsRise), .oFall(vsFall)
    );

    vga_edge_detect #(.ResetValue(1'b0)) uDispEdge (
        .Clock(Clock), .Reset(Reset), .iSignal(iDisplay),
        .oSample(dispSample), .oRise(dispRise), .oFall(dispFall)
    );

    assign unusedSignals = ^{hsSample, hsRise, vsSample, vsRise};

    syncStateT             rState, stateNext;
    logic [15:0]           rPeriod, periodNext;
    logic [MatchWidth-1:0] rMatch, matchNext;
    logic                  lockNext;
    logic                  syncEdge, timeout, syncError;
    logic                  rColOvf, rRowOvf, colOverflow, rowOverflow;

    // Simultaneous HSync and VSync falls collapse into a single sync edge.
    assign syncEdge = hsFall | vsFall;
    assign timeout  = !syncEdge && (rPeriod == MaxPeriod);

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        stateNext  = rState;
        periodNext = oLinePeriod;
        matchNext  = rMatch;
        lockNext   = oLocked;
        syncError  = 1'b0;
        if (timeout) begin
            stateNext = STATE_HUNT;
            lockNext  = 1'b0;
            syncError = oLocked;
        end else if (syncEdge) begin
            unique case (rState)
                STATE_HUNT: stateNext = STATE_MEASURE;
                STATE_MEASURE: begin
                    periodNext = rPeriod;
                    matchNext  = '0;
                    stateNext  = STATE_TRACK;
                end
                STATE_TRACK: begin
                    if (rPeriod == oLinePeriod) begin
                        if (rMatch != MatchFull) matchNext = rMatch + MatchStep;
                        if (rMatch == MatchLast || rMatch == MatchFull) lockNext = 1'b1;
                    end else begin
                        periodNext = rPeriod;
                        matchNext  = '0;
                        lockNext   = 1'b0;
                        syncError  = oLocked;
                    end
                end
                default: stateNext = STATE_HUNT;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rState      <= STATE_HUNT;
            rPeriod     <= '0;
            rMatch      <= '0;
            oLinePeriod <= '0;
            oLocked     <= 1'b0;
        end else begin
            rState      <= stateNext;
            rMatch      <= matchNext;
            oLinePeriod <= periodNext;
            oLocked     <= lockNext;
            if (syncEdge) begin
                rPeriod <= 16'd1;
            end else if (rPeriod != 16'hFFFF) begin
                rPeriod <= rPeriod + 16'd1;
            end
        end
    end

    // Overflow flags limit each coordinate fault to a single error pulse.
    assign colOverflow = dispSample && !dispRise && (oCol == ColMax) && !rColOvf;
    assign rowOverflow = dispFall && !vsFall && (oRow == RowMax) && !rRowOvf;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oCol        <= '0;
            oRow        <= '0;
            oPixelValid <= 1'b0;
            oFrameStart <= 1'b0;
            oError      <= 1'b0;
            rColOvf     <= 1'b0;
            rRowOvf     <= 1'b0;
        end else begin
            oPixelValid <= dispSample;
            oFrameStart <= vsFall;
            oError      <= syncError | colOverflow | rowOverflow;

            if (dispRise) begin
                oCol    <= '0;
                rColOvf <= 1'b0;
            end else if (dispSample) begin
                if (oCol != ColMax) oCol <= oCol + ColStep;
                else                rColOvf <= 1'b1;
            end

            if (vsFall) begin
                oRow    <= '0;
                rRowOvf <= 1'b0;
            end else if (dispFall) begin
                if (oRow != RowMax) oRow <= oRow + RowStep;
                else                rRowOvf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver: line-level stimulus feeds an event
// model; a negedge monitor pops and compares whatever the DUT presents.
module tb_vga_sync_receiver;
    import vga_pkg::*;

    localparam int XLen      = 256;
    localparam int YLen      = 256;
    localparam int LockLines = 4;
    localparam int MaxPeriod = 2047;
    localparam int LineLen   = HSyncPulse + BackPorch + 256 + FrontPorch;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iHSync = 1'b1, iVSync = 1'b1, iDisplay = 1'b0;
    logic [7:0]  oCol, oRow;
    logic        oPixelValid, oFrameStart, oLocked, oError;
    logic [15:0] oLinePeriod;

    vga_sync_receiver #(
        .XWidth(8), .YWidth(8), .X_length(XLen), .Y_length(YLen),
        .LockLines(LockLines), .MaxPeriod(16'(MaxPeriod))
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .iHSync(iHSync), .iVSync(iVSync), .iDisplay(iDisplay),
        .oCol(oCol), .oRow(oRow), .oPixelValid(oPixelValid),
        .oFrameStart(oFrameStart), .oLocked(oLocked),
        .oLinePeriod(oLinePeriod), .oError(oError)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct { int cyc; int col; int row; } pixT;
    typedef struct { int cyc; bit locked; int period; } statT;

    pixT  pixQ[$];
    statT statQ[$];
    int   frameQ[$];
    int   errQ[$];
    int   tests = 0;
    int   fails = 0;

    // Event model state: times are in pin cycles; DUT shows effects two cycles later.
    bit mHaveLast, mHaveRef, mLocked, mRowOvf;
    int mLastSe, mRef, mRun, mShownPeriod, mRow;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT presented an event the model did not expect (cycle %0d)", name, cyc);
    endtask

    task automatic modelReset();
        mHaveLast = 0; mHaveRef = 0; mLocked = 0; mRowOvf = 0;
        mLastSe = 0; mRef = 0; mRun = 0; mShownPeriod = 0; mRow = 0;
    endtask

    task automatic pushErr(input int c);
        if (errQ.size() == 0 || errQ[$] != c) errQ.push_back(c);
    endtask

    task automatic pushStatus(input int c, input bit lk, input int p);
        if (lk != mLocked || p != mShownPeriod) begin
            statQ.push_back(statT'{c, lk, p});
            mLocked = lk;
            mShownPeriod = p;
        end
    endtask

    // A gap longer than MaxPeriod since the last sync edge drops lock and restarts the search.
    task automatic modelTimeout(input int tEnd);
        int tOut;
        tOut = mLastSe + MaxPeriod;
        if (mHaveLast && tOut < tEnd) begin
            if (mLocked) pushErr(tOut + 2);
            pushStatus(tOut + 2, 1'b0, mShownPeriod);
            mHaveLast = 0;
            mHaveRef = 0;
        end
    endtask

    task automatic modelSe(input int t);
        int p;
        if (mHaveLast) begin
            p = t - mLastSe;
            if (!mHaveRef) begin
                mHaveRef = 1; mRef = p; mRun = 0;
                pushStatus(t + 2, mLocked, p);
            end else if (p == mRef) begin
                if (mRun < LockLines) mRun++;
                if (mRun == LockLines) pushStatus(t + 2, 1'b1, mRef);
            end else begin
                if (mLocked) pushErr(t + 2);
                mRef = p; mRun = 0;
                pushStatus(t + 2, 1'b0, p);
            end
        end
        mHaveLast = 1;
        mLastSe = t;
    endtask

    // One line: sync pulse (HSync, or VSync when isV), back porch, display, front porch.
    task automatic sendLine(input bit isV, input int pulse, input int bp, input int disp,
                            input int fp, input int stopAfter = 1 << 30);
        int t0, d0, total;
        @(negedge Clock);
        t0 = cyc;
        total = pulse + bp + disp + fp;
        modelTimeout(t0);
        modelSe(t0);
        if (isV) begin
            frameQ.push_back(t0 + 2);
            mRow = 0;
            mRowOvf = 0;
        end
        if (disp > 0) begin
            d0 = t0 + pulse + bp;
            for (int k = 0; k < disp; k++)
                pixQ.push_back(pixT'{d0 + 2 + k, (k < XLen) ? k : XLen - 1, mRow});
            if (disp > XLen) pushErr(d0 + 2 + XLen);
            if (mRow == YLen - 1) begin
                if (!mRowOvf) pushErr(d0 + disp + 2);
                mRowOvf = 1;
            end else begin
                mRow++;
            end
        end
        for (int i = 0; i < total && i < stopAfter; i++) begin
            if (i > 0) @(negedge Clock);
            iHSync   = !(!isV && i < pulse);
            iVSync   = !(isV && i < pulse);
            iDisplay = (i >= pulse + bp) && (i < pulse + bp + disp);
        end
    endtask

    task automatic normalLine(input int extra = 0, input int stopAfter = 1 << 30);
        int disp;
        disp = ($urandom_range(0, 1) == 1) ? 256 : int'($urandom_range(200, 255));
        sendLine(1'b0, HSyncPulse, BackPorch, disp, LineLen - HSyncPulse - BackPorch - disp + extra, stopAfter);
    endtask

    task automatic vsyncLine();
        sendLine(1'b1, HSyncPulse, BackPorch, 0, LineLen - HSyncPulse - BackPorch);
    endtask

    task automatic idle(input int n);
        @(negedge Clock);
        modelTimeout(cyc + n);
        iHSync = 1'b1; iVSync = 1'b1; iDisplay = 1'b0;
        repeat (n - 1) @(negedge Clock);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " oCol"}, oCol, 0);
        check({tag, " oRow"}, oRow, 0);
        check({tag, " oPixelValid"}, oPixelValid, 0);
        check({tag, " oFrameStart"}, oFrameStart, 0);
        check({tag, " oLocked"}, oLocked, 0);
        check({tag, " oLinePeriod"}, oLinePeriod, 0);
        check({tag, " oError"}, oError, 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    logic        prevLocked = 1'b0;
    logic [15:0] prevPeriod = '0;
    pixT         ePix;
    statT        eStat;

    initial begin
        forever begin
            @(negedge Clock);
            if (Reset) begin
                if (oPixelValid) begin
                    if (pixQ.size() == 0) unexpected("pixel");
                    else begin
                        ePix = pixQ.pop_front();
                        check("pixel cycle", cyc, ePix.cyc);
                        check("oCol", oCol, ePix.col);
                        check("oRow", oRow, ePix.row);
                    end
                end
                if (oFrameStart) begin
                    if (frameQ.size() == 0) unexpected("oFrameStart");
                    else check("frame start cycle", cyc, frameQ.pop_front());
                end
                if (oError) begin
                    if (errQ.size() == 0) unexpected("oError");
                    else check("error cycle", cyc, errQ.pop_front());
                end
                if (oLocked !== prevLocked || oLinePeriod !== prevPeriod) begin
                    if (statQ.size() == 0) unexpected("lock/period change");
                    else begin
                        eStat = statQ.pop_front();
                        check("status cycle", cyc, eStat.cyc);
                        check("oLocked", oLocked, eStat.locked);
                        check("oLinePeriod", oLinePeriod, eStat.period);
                    end
                end
            end
            prevLocked = oLocked;
            prevPeriod = oLinePeriod;
        end
    end

    initial begin
        int sp, sd;
        modelReset();
        #1 Reset = 1'b0;
        #1 checkAllZero("reset");
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        // Acquire lock, then end the frame with a VSync line.
        repeat (7) normalLine();
        vsyncLine();

        // Stretched line while locked, relock, display overrun, frame end.
        repeat (2) normalLine();
        normalLine(4);
        repeat (6) normalLine();
        sendLine(1'b0, HSyncPulse, 4, 300, LineLen - HSyncPulse - 4 - 300);
        vsyncLine();

        // Syncs held high past the timeout.
        idle(2100);

        // Relock from HUNT, then an asynchronous reset in the middle of a line.
        repeat (7) normalLine();
        normalLine(0, 200);
        #2 Reset = 1'b0;
        #1 checkAllZero("async reset");
        pixQ.delete(); statQ.delete(); frameQ.delete(); errQ.delete();
        modelReset();
        iHSync = 1'b1; iVSync = 1'b1; iDisplay = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;

        repeat (6) normalLine();
        vsyncLine();

        // Short-line frame long enough to saturate the row counter.
        sp = $urandom_range(18, 24);
        sendLine(1'b1, 4, 4, 0, sp - 8);
        for (int n = 0; n < YLen + 2; n++) begin
            sd = $urandom_range(2, 6);
            sendLine(1'b0, 4, 4, sd, sp - 8 - sd);
        end
        idle(20);

        check("pixels outstanding", pixQ.size(), 0);
        check("frame starts outstanding", frameQ.size(), 0);
        check("errors outstanding", errQ.size(), 0);
        check("status changes outstanding", statQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
